// File: rtl/spi_trace_tx_if.sv
// Bus bundle for the spi_trace_tx debug trace serializer.
// The master side drives the capture request and the four trace words;
// the slave side (the serializer) drives the serial pins and status flags.
interface spi_trace_tx_if #(
    parameter int WIDTH = 32
);
    logic             capture;
    logic [3:0]       ch_valid;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] imem_data;
    logic [WIDTH-1:0] dmem_wdata;
    logic [WIDTH-1:0] dmem_rdata;

    logic             busy;
    logic             spi_sck;
    logic             pc_cs;
    logic             imem_data_cs;
    logic             dmem_wdata_cs;
    logic             dmem_rdata_cs;
    logic             pc_mosi;
    logic             imem_data_mosi;
    logic             dmem_wdata_mosi;
    logic             dmem_rdata_mosi;
    logic             overrun;

    modport master (
        output capture, ch_valid, pc, imem_data, dmem_wdata, dmem_rdata,
        input  busy, spi_sck, pc_cs, imem_data_cs, dmem_wdata_cs, dmem_rdata_cs,
        input  pc_mosi, imem_data_mosi, dmem_wdata_mosi, dmem_rdata_mosi, overrun
    );

    modport slave (
        input  capture, ch_valid, pc, imem_data, dmem_wdata, dmem_rdata,
        output busy, spi_sck, pc_cs, imem_data_cs, dmem_wdata_cs, dmem_rdata_cs,
        output pc_mosi, imem_data_mosi, dmem_wdata_mosi, dmem_rdata_mosi, overrun
    );
endinterface

// File: rtl/spi_trace_tx.sv
// spi_trace_tx: four-channel parallel SPI trace serializer.
// A capture strobe latches pc / imem_data / dmem_wdata / dmem_rdata and the
// channel-valid mask, then shifts all words MSB-first on one shared sck.
// Channel index: 0 pc, 1 imem_data, 2 dmem_wdata, 3 dmem_rdata.
// Optional build macro TRACE_SKID_EN adds a one-entry skid buffer that holds
// a capture arriving mid-frame and starts it right after the current HOLD.
module spi_trace_tx #(
    parameter int WIDTH  = 32,
    parameter int CLKDIV = 2
) (
    input  logic          clk,
    input  logic          rst,
    spi_trace_tx_if.slave bus
);
    localparam int       CW       = $clog2(WIDTH + 1);
    localparam logic [7:0] DIV_LAST = 8'(CLKDIV - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SETUP    = 3'd1,
        SHIFT_HI = 3'd2,
        SHIFT_LO = 3'd3,
        HOLD     = 3'd4
    } state_t;

    state_t                 state;
    logic [7:0]             div_cnt;
    logic [CW-1:0]          bits_left;
    logic [3:0][WIDTH-1:0]  shreg;
    logic [3:0]             mask;
    logic                   busy_q;
    logic                   sck_q;
    logic [3:0]             cs_q;
    logic [3:0]             mosi_q;
    logic                   overrun_q;

    logic                   div_done;
    logic                   start;
    logic [3:0][WIDTH-1:0]  in_words;
    logic [3:0][WIDTH-1:0]  load_words;
    logic [3:0]             load_mask;

`ifdef TRACE_SKID_EN
    logic                   skid_full;
    logic [3:0][WIDTH-1:0]  skid_words;
    logic [3:0]             skid_mask;
`endif

    assign in_words[0] = bus.pc;
    assign in_words[1] = bus.imem_data;
    assign in_words[2] = bus.dmem_wdata;
    assign in_words[3] = bus.dmem_rdata;

    // Half-period terminal count and frame-start decision.
    always_comb begin
        div_done = (div_cnt == DIV_LAST);
        case (state)
            IDLE:    start = bus.capture;
`ifdef TRACE_SKID_EN
            HOLD:    start = div_done & (skid_full | bus.capture);
`endif
            default: start = 1'b0;
        endcase
    end

    // Pick the frame source: a held skid entry takes priority over live inputs.
    always_comb begin
`ifdef TRACE_SKID_EN
        if (skid_full) begin
            load_words = skid_words;
            load_mask  = skid_mask;
        end else begin
            load_words = in_words;
            load_mask  = bus.ch_valid;
        end
`else
        load_words = in_words;
        load_mask  = bus.ch_valid;
`endif
    end

    // Frame sequencer: state, half-period divider, shifters and serial pins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            div_cnt   <= 8'd0;
            bits_left <= '0;
            shreg     <= '0;
            mask      <= 4'b0000;
            busy_q    <= 1'b0;
            sck_q     <= 1'b0;
            cs_q      <= 4'b1111;
            mosi_q    <= 4'b0000;
        end else if (start) begin
            state     <= SETUP;
            div_cnt   <= 8'd0;
            bits_left <= CW'(WIDTH);
            shreg     <= load_words;
            mask      <= load_mask;
            busy_q    <= 1'b1;
            sck_q     <= 1'b0;
            cs_q      <= ~load_mask;
            for (int i = 0; i < 4; i++) begin
                mosi_q[i] <= load_mask[i] & load_words[i][WIDTH-1];
            end
        end else begin
            case (state)
                IDLE: begin
                    div_cnt <= 8'd0;
                end
                SETUP: begin
                    if (div_done) begin
                        div_cnt <= 8'd0;
                        sck_q   <= 1'b1;
                        state   <= SHIFT_HI;
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                SHIFT_HI: begin
                    if (div_done) begin
                        div_cnt   <= 8'd0;
                        sck_q     <= 1'b0;
                        state     <= SHIFT_LO;
                        bits_left <= bits_left - CW'(1);
                        // Next bit goes out on the falling edge; the last bit
                        // stays on the wire through its low phase.
                        if (bits_left != CW'(1)) begin
                            for (int i = 0; i < 4; i++) begin
                                shreg[i]  <= {shreg[i][WIDTH-2:0], 1'b0};
                                mosi_q[i] <= mask[i] & shreg[i][WIDTH-2];
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                SHIFT_LO: begin
                    if (div_done) begin
                        div_cnt <= 8'd0;
                        if (bits_left == CW'(0)) begin
                            cs_q   <= 4'b1111;
                            mosi_q <= 4'b0000;
                            state  <= HOLD;
                        end else begin
                            sck_q <= 1'b1;
                            state <= SHIFT_HI;
                        end
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                HOLD: begin
                    if (div_done) begin
                        div_cnt <= 8'd0;
                        busy_q  <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    div_cnt <= 8'd0;
                    busy_q  <= 1'b0;
                    sck_q   <= 1'b0;
                    cs_q    <= 4'b1111;
                    mosi_q  <= 4'b0000;
                end
            endcase
        end
    end

`ifdef TRACE_SKID_EN
    // Skid buffer fill/drain and sticky overrun when the buffer is already full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_full  <= 1'b0;
            skid_words <= '0;
            skid_mask  <= 4'b0000;
            overrun_q  <= 1'b0;
        end else if (start && skid_full) begin
            // Entry drains into the new frame; a capture on this edge refills it.
            skid_full <= bus.capture;
            if (bus.capture) begin
                skid_words <= in_words;
                skid_mask  <= bus.ch_valid;
            end else begin
                skid_words <= skid_words;
                skid_mask  <= skid_mask;
            end
        end else if (bus.capture && busy_q && !start) begin
            if (skid_full) begin
                overrun_q <= 1'b1;
            end else begin
                skid_full  <= 1'b1;
                skid_words <= in_words;
                skid_mask  <= bus.ch_valid;
            end
        end else begin
            skid_full <= skid_full;
        end
    end
`else
    // Sticky overrun: any capture while a frame is in flight is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun_q <= 1'b0;
        end else if (bus.capture && busy_q) begin
            overrun_q <= 1'b1;
        end else begin
            overrun_q <= overrun_q;
        end
    end
`endif

    assign bus.busy            = busy_q;
    assign bus.spi_sck         = sck_q;
    assign bus.pc_cs           = cs_q[0];
    assign bus.imem_data_cs    = cs_q[1];
    assign bus.dmem_wdata_cs   = cs_q[2];
    assign bus.dmem_rdata_cs   = cs_q[3];
    assign bus.pc_mosi         = mosi_q[0];
    assign bus.imem_data_mosi  = mosi_q[1];
    assign bus.dmem_wdata_mosi = mosi_q[2];
    assign bus.dmem_rdata_mosi = mosi_q[3];
    assign bus.overrun         = overrun_q;
endmodule
